// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: control-field bit positions,
// default datapath widths and the memory-stage state encoding.
package cpu_pkg;

    localparam int REG_WIDTH    = 16;
    localparam int ADDR_BITS    = 3;
    localparam int CONTROL_BITS = 4;

    localparam int CTRL_MEMREAD  = 0;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_REGWRITE = 2;
    localparam int CTRL_MEMTOREG = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_stage_unit.sv
// Memory-access stage: ALU results pass straight to MEM/WB; loads and stores hold
// the pipeline through a req/ack handshake guarded by a watchdog with a sticky error.
module mem_stage_unit
    import cpu_pkg::*;
#(
    parameter int RegWidth      = REG_WIDTH,
    parameter int AddrBits      = ADDR_BITS,
    parameter int ControlBits   = CONTROL_BITS,
    parameter int TimeoutCycles = 15
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   Valid_In,
    input  logic [ControlBits-1:0] Control_In,
    input  logic [RegWidth-1:0]    ALUOut_In,
    input  logic [RegWidth-1:0]    MemData_In,
    input  logic [AddrBits-1:0]    DestReg_In,
    output logic                   Stall,
    output logic                   Mem_Req,
    output logic                   Mem_We,
    output logic [RegWidth-1:0]    Mem_Addr,
    output logic [RegWidth-1:0]    Mem_WData,
    input  logic [RegWidth-1:0]    Mem_RData,
    input  logic                   Mem_Ack,
    output logic                   WB_Valid,
    output logic                   WB_RegWrite,
    output logic [AddrBits-1:0]    WB_DestReg,
    output logic [RegWidth-1:0]    WB_Data,
    output logic                   Mem_Err
);

    localparam logic [7:0] CntLimit = 8'(TimeoutCycles - 1);

    mem_state_e             state_q, state_d;
    logic [ControlBits-1:0] ctrl_q, ctrl_d;
    logic [RegWidth-1:0]    addr_q, addr_d;
    logic [RegWidth-1:0]    wdata_q, wdata_d;
    logic [AddrBits-1:0]    dest_q, dest_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   wb_valid_q, wb_valid_d;
    logic                   wb_rw_q, wb_rw_d;
    logic [AddrBits-1:0]    wb_dest_q, wb_dest_d;
    logic [RegWidth-1:0]    wb_data_q, wb_data_d;
    logic                   err_q, err_d;

    logic in_is_mem;
    logic lat_is_load;

    assign in_is_mem   = Control_In[CTRL_MEMREAD] | Control_In[CTRL_MEMWRITE];
    // A store wins when both bits are set, so only a pure read may return memory data.
    assign lat_is_load = ctrl_q[CTRL_MEMREAD] & ~ctrl_q[CTRL_MEMWRITE]
                       & ctrl_q[CTRL_MEMTOREG];

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned; an incomplete assignment here would infer a latch.
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        dest_d     = dest_q;
        cnt_d      = cnt_q;
        wb_valid_d = 1'b0;
        wb_rw_d    = wb_rw_q;
        wb_dest_d  = wb_dest_q;
        wb_data_d  = wb_data_q;
        err_d      = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (Valid_In) begin
                    if (in_is_mem) begin
                        ctrl_d  = Control_In;
                        addr_d  = ALUOut_In;
                        wdata_d = MemData_In;
                        dest_d  = DestReg_In;
                        cnt_d   = 8'd0;
                        state_d = ST_BUSY;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_rw_d    = Control_In[CTRL_REGWRITE];
                        wb_dest_d  = DestReg_In;
                        wb_data_d  = ALUOut_In;
                    end
                end
            end
            ST_BUSY: begin
                // Ack is tested first so a completion on the watchdog's last cycle still retires cleanly.
                if (Mem_Ack) begin
                    wb_valid_d = 1'b1;
                    wb_rw_d    = ctrl_q[CTRL_REGWRITE];
                    wb_dest_d  = dest_q;
                    wb_data_d  = lat_is_load ? Mem_RData : addr_q;
                    state_d    = ST_IDLE;
                end else if (cnt_q == CntLimit) begin
                    wb_valid_d = 1'b1;
                    wb_rw_d    = 1'b0;
                    wb_dest_d  = dest_q;
                    err_d      = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            dest_q     <= '0;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_dest_q  <= '0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            dest_q     <= dest_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_rw_q    <= wb_rw_d;
            wb_dest_q  <= wb_dest_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
        end
    end

    // Handshake outputs decode registered state only, keeping inputs off the stall path.
    assign Stall       = (state_q == ST_BUSY);
    assign Mem_Req     = (state_q == ST_BUSY);
    assign Mem_We      = ctrl_q[CTRL_MEMWRITE];
    assign Mem_Addr    = addr_q;
    assign Mem_WData   = wdata_q;
    assign WB_Valid    = wb_valid_q;
    assign WB_RegWrite = wb_rw_q;
    assign WB_DestReg  = wb_dest_q;
    assign WB_Data     = wb_data_q;
    assign Mem_Err     = err_q;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Scoreboard bench for mem_stage_unit: a driver issues random instructions and plays
// the data memory; a monitor retires WB strobes against a queue of expected results.
module tb_mem_stage_unit;
    import cpu_pkg::*;

    localparam int TO = 15;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Valid_In;
    logic [3:0]  Control_In;
    logic [15:0] ALUOut_In, MemData_In, Mem_RData, Mem_Addr, Mem_WData, WB_Data;
    logic [2:0]  DestReg_In, WB_DestReg;
    logic        Stall, Mem_Req, Mem_We, Mem_Ack, WB_Valid, WB_RegWrite, Mem_Err;

    mem_stage_unit #(
        .RegWidth(16), .AddrBits(3), .ControlBits(4), .TimeoutCycles(TO)
    ) dut (
        .CLK(CLK), .RST(RST), .Valid_In(Valid_In), .Control_In(Control_In),
        .ALUOut_In(ALUOut_In), .MemData_In(MemData_In), .DestReg_In(DestReg_In),
        .Stall(Stall), .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr),
        .Mem_WData(Mem_WData), .Mem_RData(Mem_RData), .Mem_Ack(Mem_Ack),
        .WB_Valid(WB_Valid), .WB_RegWrite(WB_RegWrite), .WB_DestReg(WB_DestReg),
        .WB_Data(WB_Data), .Mem_Err(Mem_Err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    typedef struct {
        int          cyc;
        logic        rw;
        logic [2:0]  dest;
        logic [15:0] data;
        bit          timeout;
    } wb_t;

    wb_t sb[$];
    int  errors = 0;
    int  checks = 0;
    bit  exp_err = 1'b0;

    // Reference data memory; unwritten locations read back a fixed address hash.
    bit [15:0] mem_m [bit [15:0]];

    function automatic logic [15:0] mem_rd(bit [15:0] a);
        return mem_m.exists(a) ? mem_m[a] : (a ^ 16'h5A5A);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every WB strobe must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        wb_t e;
        if (RST === 1'b1 && WB_Valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: WB_Valid high with nothing outstanding (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("wb_cycle", cyc, e.cyc);
                check("wb_regwrite", WB_RegWrite, e.rw);
                if (!e.timeout) begin
                    check("wb_dest", WB_DestReg, e.dest);
                    check("wb_data", WB_Data, e.data);
                end
            end
        end
    end

    // All driver tasks start and end on a falling edge.
    task automatic idle_cycle(bit stray_ack);
        Valid_In  = 1'b0;
        Mem_Ack   = stray_ack;
        Mem_RData = 16'($urandom);
        @(negedge CLK);
        Mem_Ack = 1'b0;
    endtask

    // delay = number of BUSY cycles before ack; 0 means never acknowledge.
    task automatic run_op(logic [3:0] ctrl, logic [15:0] alu, logic [15:0] wd,
                          logic [2:0] dest, int delay);
        bit  is_mem = ctrl[0] | ctrl[1];
        bit  is_wr  = ctrl[1];
        bit  is_ld  = ctrl[0] & ~ctrl[1] & ctrl[3];
        int  nbusy;
        wb_t e;

        check("stall_at_issue", Stall, 1'b0);
        Valid_In   = 1'b1;
        Control_In = ctrl;
        ALUOut_In  = alu;
        MemData_In = wd;
        DestReg_In = dest;
        Mem_Ack    = 1'b0;

        e.dest    = dest;
        e.timeout = 1'b0;
        if (!is_mem) begin
            e.cyc  = cyc + 1;
            e.rw   = ctrl[2];
            e.data = alu;
            sb.push_back(e);
            @(negedge CLK);
            return;
        end

        nbusy = (delay == 0) ? TO : delay;
        if (delay == 0) begin
            e.cyc     = cyc + 1 + TO;
            e.rw      = 1'b0;
            e.data    = '0;
            e.timeout = 1'b1;
        end else begin
            e.cyc  = cyc + 1 + delay;
            e.rw   = ctrl[2];
            e.data = is_ld ? mem_rd(alu) : alu;
        end
        if (is_wr) mem_m[alu] = wd;
        sb.push_back(e);
        @(negedge CLK);

        for (int i = 1; i <= nbusy; i++) begin
            Valid_In   = 1'($urandom);
            Control_In = 4'($urandom);
            ALUOut_In  = 16'($urandom);
            check("busy_req", Mem_Req, 1'b1);
            check("busy_stall", Stall, 1'b1);
            check("busy_we", Mem_We, is_wr);
            check("busy_addr", Mem_Addr, alu);
            check("busy_wdata", Mem_WData, wd);
            if (i == delay) begin
                Mem_Ack   = 1'b1;
                Mem_RData = is_wr ? 16'($urandom) : mem_rd(Mem_Addr);
            end
            @(negedge CLK);
        end
        Mem_Ack  = 1'b0;
        Valid_In = 1'b0;
        if (delay == 0) exp_err = 1'b1;
        check("exit_req", Mem_Req, 1'b0);
        check("exit_stall", Stall, 1'b0);
        check("mem_err", Mem_Err, exp_err);
    endtask

    task automatic random_op();
        logic [3:0] c = 4'($urandom);
        if ($urandom_range(0, 3) == 0) idle_cycle($urandom_range(0, 1) == 1);
        run_op(c, 16'($urandom_range(0, 31)), 16'($urandom), 3'($urandom),
               $urandom_range(1, 6));
    endtask

    initial begin
        RST        = 1'b0;
        Valid_In   = 1'b0;
        Control_In = '0;
        ALUOut_In  = '0;
        MemData_In = '0;
        DestReg_In = '0;
        Mem_RData  = '0;
        Mem_Ack    = 1'b0;

        repeat (2) @(negedge CLK);
        check("rst_stall", Stall, 1'b0);
        check("rst_req", Mem_Req, 1'b0);
        check("rst_we", Mem_We, 1'b0);
        check("rst_addr", Mem_Addr, 16'h0);
        check("rst_wdata", Mem_WData, 16'h0);
        check("rst_wb_valid", WB_Valid, 1'b0);
        check("rst_wb_rw", WB_RegWrite, 1'b0);
        check("rst_wb_dest", WB_DestReg, 3'h0);
        check("rst_wb_data", WB_Data, 16'h0);
        check("rst_err", Mem_Err, 1'b0);
        RST = 1'b1;
        @(negedge CLK);

        // Directed cases: ALU pass-through, 3-cycle load, 1-cycle store, ack on the watchdog edge.
        run_op(4'b0100, 16'd35, 16'd0, 3'd5, 0);
        check("alu_stall_after", Stall, 1'b0);
        mem_m[16'h0040] = 16'hBEEF;
        run_op(4'b1101, 16'h0040, 16'd0, 3'd3, 3);
        run_op(4'b0010, 16'h0010, 16'd45, 3'd1, 1);
        run_op(4'b1101, 16'h0022, 16'd0, 3'd6, TO);

        // Back-to-back ALU, load, ALU.
        run_op(4'b0100, 16'h1111, 16'd0, 3'd2, 0);
        run_op(4'b1101, 16'h0040, 16'd0, 3'd4, 2);
        run_op(4'b0100, 16'h2222, 16'd0, 3'd7, 0);

        for (int n = 0; n < 150; n++) random_op();

        // Hung load: watchdog abort, then the error must stay set.
        run_op(4'b1101, 16'h0033, 16'd0, 3'd1, 0);
        for (int n = 0; n < 20; n++) random_op();

        // Reset during the second BUSY cycle.
        check("stall_at_issue", Stall, 1'b0);
        Valid_In   = 1'b1;
        Control_In = 4'b1101;
        ALUOut_In  = 16'h0055;
        DestReg_In = 3'd2;
        @(negedge CLK);
        Valid_In = 1'b0;
        @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        check("rstmid_req", Mem_Req, 1'b0);
        check("rstmid_stall", Stall, 1'b0);
        check("rstmid_err", Mem_Err, 1'b0);
        check("rstmid_wb_valid", WB_Valid, 1'b0);
        exp_err = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        idle_cycle(1'b1);
        idle_cycle(1'b0);
        check("stray_ack_req", Mem_Req, 1'b0);

        for (int n = 0; n < 30; n++) random_op();

        repeat (3) idle_cycle(1'b0);
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
